// File: rtl/omem_potential_store.sv
// Output-memory store for the SPE mesh: neuron potentials/spikes, read-back, timestep tracking; OMEM_SPIKE_CNT_EN adds a spike counter.
// Writes visible next edge; read response valid 2 edges after accept; out_* held while !out_ready; in_ready low while busy.
module omem_potential_store #(
  parameter int NUM_SPE       = 3,
  parameter int OUTS_PER_SPE  = 147,
  parameter int NUM_TIMESTEPS = 2,
  parameter int SPE_BASE_ID   = 9,
  parameter int POT_W         = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_dest,
  output logic [3:0]  out_opcode,
  output logic [24:0] out_data,
  output logic [1:0]  ts,
  output logic        done,
  output logic        err,
  output logic [8:0]  spike_cnt
);
  localparam int DEPTH = NUM_SPE * OUTS_PER_SPE;
  localparam int PW    = $clog2(OUTS_PER_SPE + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, RD, RESP, BCAST, FIN} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    wp [NUM_SPE];
  logic [PW-1:0]    rp [NUM_SPE];
  logic [CW-1:0]    wcnt;
  logic [2:0]       cur_spe;
  logic [2:0]       bc_idx;
  logic [POT_W-1:0] pot_mem [DEPTH];
  logic             spk_mem [DEPTH];
  logic [POT_W-1:0] rd_pot;
  logic             rd_spk;

  logic [2:0]    req_spe;
  logic          req_rd;
  logic [PW-1:0] wp_sel, rp_sel, rp_cur;
  logic          id_ok, req_bad;
  logic          wr_ok, rd_ok, req_err, ts_end;
  logic          resp_load, resp_done, bc_start, bc_step, bc_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          unused_bits;

  assign req_spe     = in_opcode[3:1];
  assign req_rd      = in_opcode[0];
  assign unused_bits = ^{in_data[24:POT_W+1], rd_spk};

  function automatic logic [AW-1:0] mem_addr(input logic [2:0] k, input logic [PW-1:0] p);
    return AW'(int'(k) * OUTS_PER_SPE + int'(p));
  endfunction

  // Pointer muxes are loop-compared so an out-of-range id never indexes the arrays.
  always_comb begin
    wp_sel = '0;
    rp_sel = '0;
    rp_cur = '0;
    for (int i = 0; i < NUM_SPE; i++) begin
      if (req_spe == 3'(i)) begin
        wp_sel = wp[i];
        rp_sel = rp[i];
      end
      if (cur_spe == 3'(i)) rp_cur = rp[i];
    end
  end

  assign id_ok   = (int'(req_spe) < NUM_SPE);
  assign req_bad = !id_ok
                || (req_rd && ts == 2'd1)
                || (!req_rd && wp_sel == PW'(OUTS_PER_SPE))
                || (req_rd && rp_sel == PW'(OUTS_PER_SPE));
  assign wr_addr = mem_addr(req_spe, wp_sel);
  assign rd_addr = mem_addr(cur_spe, rp_cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ok     = 1'b0;
    rd_ok     = 1'b0;
    req_err   = 1'b0;
    ts_end    = 1'b0;
    resp_load = 1'b0;
    resp_done = 1'b0;
    bc_start  = 1'b0;
    bc_step   = 1'b0;
    bc_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (req_bad) begin
            req_err = 1'b1;
          end else if (req_rd) begin
            rd_ok     = 1'b1;
            state_nxt = RD;
          end else begin
            wr_ok = 1'b1;
            if (wcnt == CW'(DEPTH - 1)) begin
              ts_end = 1'b1;
              if (ts == 2'd1) begin
                if (NUM_TIMESTEPS == 1) begin
                  state_nxt = FIN;
                end else begin
                  state_nxt = BCAST;
                  bc_start  = 1'b1;
                end
              end else if (ts == 2'(NUM_TIMESTEPS)) begin
                state_nxt = FIN;
              end
            end
          end
        end
      end
      RD: state_nxt = RESP;
      // First RESP cycle loads the output registers; handshake follows.
      RESP: begin
        if (!out_valid) begin
          resp_load = 1'b1;
        end else if (out_ready) begin
          resp_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      BCAST: begin
        if (out_valid && out_ready) begin
          if (bc_idx == 3'(NUM_SPE - 1)) begin
            bc_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            bc_step = 1'b1;
          end
        end
      end
      FIN: state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_dest   <= '0;
      out_opcode <= '0;
      out_data   <= '0;
      ts         <= 2'd1;
      done       <= 1'b0;
      err        <= 1'b0;
      wcnt       <= '0;
      cur_spe    <= '0;
      bc_idx     <= '0;
      for (int i = 0; i < NUM_SPE; i++) begin
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      in_ready <= (state_nxt == IDLE);
      done     <= (state_nxt == FIN);
      if (req_err) err <= 1'b1;
      if (rd_ok) cur_spe <= req_spe;

      if (ts_end) begin
        wcnt <= '0;
        for (int i = 0; i < NUM_SPE; i++) begin
          wp[i] <= '0;
          rp[i] <= '0;
        end
      end else begin
        if (wr_ok) begin
          wcnt <= wcnt + 1'b1;
          for (int i = 0; i < NUM_SPE; i++)
            if (req_spe == 3'(i)) wp[i] <= wp[i] + 1'b1;
        end
        if (state == RD) begin
          for (int i = 0; i < NUM_SPE; i++)
            if (cur_spe == 3'(i)) rp[i] <= rp[i] + 1'b1;
        end
      end

      if (bc_done) ts <= 2'd2;
      else if (ts_end && ts != 2'd1 && ts != 2'(NUM_TIMESTEPS)) ts <= ts + 2'd1;

      if (bc_start) begin
        out_valid  <= 1'b1;
        out_dest   <= 4'(SPE_BASE_ID);
        out_opcode <= 4'd15;
        out_data   <= '0;
        bc_idx     <= '0;
      end else if (resp_load) begin
        out_valid  <= 1'b1;
        out_dest   <= 4'(SPE_BASE_ID + int'(cur_spe));
        out_opcode <= 4'd2;
        out_data   <= {{(25 - POT_W){1'b0}}, rd_pot};
      end else if (bc_step) begin
        out_dest <= out_dest + 4'd1;
        bc_idx   <= bc_idx + 3'd1;
      end else if (resp_done || bc_done) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Storage is not reset; reads only ever target slots written in an earlier timestep.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      pot_mem[wr_addr] <= in_data[POT_W:1];
      spk_mem[wr_addr] <= in_data[0];
    end
    if (state == RD) begin
      rd_pot <= pot_mem[rd_addr];
      rd_spk <= spk_mem[rd_addr];
    end
  end

`ifdef OMEM_SPIKE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          spike_cnt <= '0;
    else if (ts_end)                                     spike_cnt <= '0;
    else if (wr_ok && in_data[0] && spike_cnt != 9'd511) spike_cnt <= spike_cnt + 9'd1;
  end
`else
  assign spike_cnt = '0;
`endif

endmodule

// File: tb/tb_omem_potential_store.sv
// Directed bench for omem_potential_store with a request-level reference model and a per-cycle packet checker.
module tb_omem_potential_store;
  localparam int NS = 2;
  localparam int NO = 4;
  localparam int NT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [24:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_dest;
  logic [3:0]  out_opcode;
  logic [24:0] out_data;
  logic [1:0]  ts;
  logic        done;
  logic        err;
  logic [8:0]  spike_cnt;

  always #5 clk = ~clk;

  omem_potential_store #(
    .NUM_SPE(NS), .OUTS_PER_SPE(NO), .NUM_TIMESTEPS(NT), .SPE_BASE_ID(9), .POT_W(13)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_opcode(out_opcode), .out_data(out_data),
    .ts(ts), .done(done), .err(err), .spike_cnt(spike_cnt)
  );

  typedef struct packed {
    logic [3:0]  dest;
    logic [3:0]  op;
    logic [24:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_mem [NS][NO];
  int m_wp [NS];
  int m_rp [NS];
  int m_wcnt, m_ts, m_spk;
  bit m_err, m_done;

`ifdef OMEM_SPIKE_CNT_EN
  localparam bit SPK_EN = 1'b1;
`else
  localparam bit SPK_EN = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_wp[k] = 0;
      m_rp[k] = 0;
    end
    m_wcnt = 0; m_ts = 1; m_spk = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_accept(input bit rd, input int spe, input int pot, input bit spk);
    pkt_t p;
    if (spe >= NS || (rd && m_ts == 1) || (!rd && m_wp[spe] == NO) || (rd && m_rp[spe] == NO)) begin
      m_err = 1;
    end else if (rd) begin
      p.dest = 4'(9 + spe);
      p.op   = 4'd2;
      p.data = 25'(m_mem[spe][m_rp[spe]]);
      exp_q.push_back(p);
      m_rp[spe]++;
    end else begin
      m_mem[spe][m_wp[spe]] = pot;
      m_wp[spe]++;
      m_wcnt++;
      if (spk && m_spk < 511) m_spk++;
      if (m_wcnt == NS * NO) begin
        for (int k = 0; k < NS; k++) begin
          m_wp[k] = 0;
          m_rp[k] = 0;
        end
        m_wcnt = 0;
        m_spk  = 0;
        if (m_ts == 1) begin
          for (int k = 0; k < NS; k++) begin
            p.dest = 4'(9 + k);
            p.op   = 4'd15;
            p.data = '0;
            exp_q.push_back(p);
          end
          m_ts = 2;
        end else begin
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_ts"}, int'(ts), m_ts);
    chk({tag, "_done"}, int'(done), int'(m_done));
    chk({tag, "_err"}, int'(err), int'(m_err));
    chk({tag, "_spike_cnt"}, int'(spike_cnt), SPK_EN ? m_spk : 0);
  endtask

  // Presents one request; returns #1 after the accepting edge.
  task automatic send(input bit rd, input int spe, input int pot, input bit spk);
    int n;
    in_opcode = {3'(spe), rd};
    in_data   = {11'd0, 13'(pot), spk};
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_ready_timeout", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_accept(rd, spe, pot, spk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", int'(in_ready), 0);
    chk("rst_out_valid_low", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Every handshake must match the next modelled packet; stalled outputs must hold.
  task automatic compare_loop();
    pkt_t cur, prev, e;
    bit   have_prev, prev_vld, prev_rdy;
    have_prev = 0; prev_vld = 0; prev_rdy = 0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_prev = 0;
      end else begin
        cur.dest = out_dest;
        cur.op   = out_opcode;
        cur.data = out_data;
        if (have_prev && prev_vld && !prev_rdy) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_fields", int'(cur == prev), 1);
        end
        if (out_valid && out_ready) begin
          chk("pkt_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pkt_dest", int'(cur.dest), int'(e.dest));
            chk("pkt_opcode", int'(cur.op), int'(e.op));
            chk("pkt_data", int'(cur.data), int'(e.data));
          end
        end
        prev = cur; prev_vld = out_valid; prev_rdy = out_ready; have_prev = 1;
      end
    end
  endtask

  int w_spe [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int w_pot [8] = '{10, 5, 20, 6, 30, 7, 40, 8};
  bit w_spk [8] = '{1, 0, 1, 0, 1, 0, 0, 0};

  initial begin
    in_valid = 0; in_opcode = 0; in_data = 0; out_ready = 1; rst_n = 0;
    fork
      compare_loop();
    join_none

    // Reset state
    do_reset();
    chk("reset_ts", int'(ts), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_spike_cnt", int'(spike_cnt), 0);
    chk("reset_out_dest", int'(out_dest), 0);
    chk("reset_out_opcode", int'(out_opcode), 0);
    chk("reset_out_data", int'(out_data), 0);

    // Bad SPE id: flagged, dropped, no pointer movement
    send(0, 5, 1, 0);
    chk("err_bad_id", int'(err), 1);
    chk("in_ready_after_err", int'(in_ready), 1);

    // Timestep 1 writes and broadcast
    for (int i = 0; i < 7; i++) send(0, w_spe[i], w_pot[i], w_spk[i]);
    chk("ts1_pre_last_ts", int'(ts), 1);
    chk("ts1_pre_last_out_valid", int'(out_valid), 0);
    chk("ts1_spike_cnt_3", int'(spike_cnt), SPK_EN ? 3 : 0);
    check_status("ts1_pre_last");
    send(0, w_spe[7], w_pot[7], w_spk[7]);
    chk("bcast0_valid", int'(out_valid), 1);
    chk("bcast0_dest", int'(out_dest), 9);
    chk("bcast0_opcode", int'(out_opcode), 15);
    chk("bcast0_data", int'(out_data), 0);
    chk("bcast_in_ready", int'(in_ready), 0);
    chk("ts_end_spike_clear", int'(spike_cnt), 0);
    @(posedge clk); #1;
    chk("bcast1_dest", int'(out_dest), 10);
    chk("bcast1_valid", int'(out_valid), 1);
    drain();
    chk("ts2_ts", int'(ts), 2);
    chk("ts2_in_ready", int'(in_ready), 1);
    check_status("ts2_start");

    // Timestep 2: SPE0 read with stalled packetizer
    out_ready = 0;
    send(1, 0, 0, 0);
    @(negedge clk);
    chk("rd1_busy", int'(in_ready), 0);
    @(negedge clk);
    chk("rd1_not_yet", int'(out_valid), 0);
    @(negedge clk);
    chk("rd1_valid", int'(out_valid), 1);
    chk("rd1_data", int'(out_data), 10);
    chk("rd1_dest", int'(out_dest), 9);
    chk("rd1_opcode", int'(out_opcode), 2);
    repeat (3) @(posedge clk);
    #1;
    chk("rd1_stall_data", int'(out_data), 10);
    chk("rd1_stall_busy", int'(in_ready), 0);
    out_ready = 1;
    drain();
    chk("rd1_ready_back", int'(in_ready), 1);

    // Write then read on SPE0
    send(0, 0, 11, 0);
    send(1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rd2_not_yet", int'(out_valid), 0);
    @(negedge clk);
    chk("rd2_valid", int'(out_valid), 1);
    chk("rd2_data", int'(out_data), 20);
    @(posedge clk); #1;
    chk("rd2_released", int'(out_valid), 0);
    chk("rd2_ready_back", int'(in_ready), 1);

    send(0, 0, 21, 0);
    send(0, 0, 31, 0);
    send(0, 0, 41, 0);

    // SPE1 reads all, then one past the end
    for (int i = 0; i < NO; i++) begin
      send(1, 1, 0, 0);
      drain();
    end
    send(1, 1, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("rd_overflow_no_resp", int'(out_valid), 0);
    check_status("ts2_mid");

    // Completion
    for (int i = 0; i < NO; i++) send(0, 1, 50 + i, 0);
    chk("fin_done", int'(done), 1);
    chk("fin_in_ready", int'(in_ready), 0);
    chk("fin_out_valid", int'(out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("fin_done_hold", int'(done), 1);
    check_status("fin");

    // Read during timestep 1
    do_reset();
    send(1, 0, 0, 0);
    chk("err_read_ts1", int'(err), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("read_ts1_no_resp", int'(out_valid), 0);

    // Write to a full SPE, then reset during broadcast
    do_reset();
    for (int i = 0; i < NO; i++) send(0, 0, 1 + i, 0);
    send(0, 0, 99, 0);
    chk("err_wp_full", int'(err), 1);
    for (int i = 0; i < NO - 1; i++) send(0, 1, 60 + i, 0);
    out_ready = 0;
    send(0, 1, 63, 0);
    chk("midb_valid", int'(out_valid), 1);
    chk("midb_dest", int'(out_dest), 9);
    repeat (2) @(posedge clk);
    #1;
    chk("midb_hold_dest", int'(out_dest), 9);
    rst_n = 0;
    exp_q.delete();
    model_reset();
    #1;
    chk("midb_rst_out_valid", int'(out_valid), 0);
    chk("midb_rst_out_dest", int'(out_dest), 0);
    chk("midb_rst_out_opcode", int'(out_opcode), 0);
    chk("midb_rst_in_ready", int'(in_ready), 0);
    chk("midb_rst_ts", int'(ts), 1);
    chk("midb_rst_err", int'(err), 0);
    chk("midb_rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk); #1;
    chk("midb_after_in_ready", int'(in_ready), 1);
    check_status("midb_after");

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/omem_potential_store.md
# omem_potential_store

Clocked output-memory controller for the spiking convolution array, at mesh address OMEM_ID. It is the store that every sum PE (SPE) talks to.
- Stores each output neuron's residual membrane potential and spike bit.
- Answers SPE requests for the previous-timestep potential.
- Tracks timestep completion and broadcasts the first-timestep-done opcode back to every SPE.

## Interface
Parameters:
- NUM_SPE, 3: number of SPEs; SPE ids are 0..NUM_SPE-1.
- OUTS_PER_SPE, 147: output neurons owned per SPE (21x21 / 3).
- NUM_TIMESTEPS, 2: timesteps per inference.
- SPE_BASE_ID, 9: mesh address of SPE k is SPE_BASE_ID+k.
- POT_W, 13: potential width.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.

Input channel (from depacketizer):
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at posedge.
- in_opcode  in  4  {spe_id[2:0], rd}; rd=1 read request, rd=0 write.
- in_data  in  25  write: [13:1]=potential, [0]=spike; ignored for reads.

Output channel (to packetizer):
- out_valid  out  1  packet valid.
- out_ready  in  1  packetizer accepts on out_valid && out_ready.
- out_dest  out  4  destination SPE address.
- out_opcode  out  4  2 = previous potential, 15 = first timestep done.
- out_data  out  25  potential zero-extended, or 0 for opcode 15.

Status:
- ts  out  2  current timestep, 1-based.
- done  out  1  high once all timesteps are complete.
- err  out  1  sticky protocol-error flag.
- spike_cnt  out  9  spikes written this timestep (see Configuration).

## Operation
Storage:
- pot_mem: NUM_SPE*OUTS_PER_SPE x POT_W.
- spk_mem: same depth, 1 bit.
- Per-SPE write pointer wp[k] and read pointer rp[k], each 0..OUTS_PER_SPE.
- Address for SPE k, pointer p = k*OUTS_PER_SPE + p.
- Global write counter wcnt.

FSM states: IDLE, RD, RESP, BCAST, FIN.
- IDLE: in_ready=1. On accept:
  - Write: store into pot_mem/spk_mem at wp[k]; wp[k]++; wcnt++; stay IDLE.
  - Read: go RD.
- RD (in_ready=0): registered memory read at rp[k]; rp[k]++; go RESP.
- RESP: out_valid=1, out_dest=SPE_BASE_ID+k, out_opcode=2, out_data={12'b0, pot}. Hold all out_* stable until out_ready, then go IDLE.
- Timestep end: when wcnt reaches NUM_SPE*OUTS_PER_SPE, the last write triggers the end of the timestep:
  - All wp, rp and wcnt clear to 0.
  - If ts==1: go BCAST.
  - Else if ts==NUM_TIMESTEPS: go FIN.
  - Otherwise ts++ and return to IDLE.
- BCAST (in_ready=0): send opcode 15 to SPE 0..NUM_SPE-1 in order, one packet per handshake. After the last handshake, ts=2 and go IDLE. If NUM_TIMESTEPS==1, go FIN directly and skip BCAST.
- FIN: done=1, in_ready=0. Exit only by reset.

Errors set err, drop the request, and move no pointer:
- spe_id >= NUM_SPE.
- Read while ts==1.
- Write with wp[k]==OUTS_PER_SPE.
- Read with rp[k]==OUTS_PER_SPE.

An erroneous read sends no response.

## Timing
- Reset values: in_ready=0 during reset, then 1 in IDLE. out_valid=0, out_dest/out_opcode/out_data=0, ts=1, done=0, err=0, spike_cnt=0, all pointers 0, state IDLE. Memory contents are not reset.
- Write accepted at edge N: memory is visible to reads from edge N+1.
- Read accepted at edge N: out_valid rises after edge N+2. in_ready is low from after edge N until the cycle after the RESP handshake.
- One request in flight at a time; no pipelining.
- out_* are registered outputs and never change while out_valid && !out_ready.
- Read and write from the same SPE back-to-back: a read of address A returns the prior timestep's value only if the write to A has not yet happened. SPEs issue read before write per neuron, so a read never observes the current timestep's write.
- rst_n asserted mid-RESP or mid-BCAST: out_valid drops asynchronously, and the pending packet is lost.

## Configuration
- OMEM_SPIKE_CNT_EN defined:
  - spike_cnt increments on each accepted write with spike=1.
  - It saturates at 511.
  - It clears at each timestep end, on the same edge as the pointer clear.
- OMEM_SPIKE_CNT_EN undefined: spike_cnt is tied to 0 and no counter logic is present.

## Test plan
All scenarios use NUM_SPE=2, OUTS_PER_SPE=4, NUM_TIMESTEPS=2 unless noted.
- Reset: after reset, ts=1, done=0, err=0, out_valid=0, in_ready=1.
- Timestep 1 and broadcast: write 4 potentials per SPE (SPE0 writes 10, 20, 30, 40) -> after the 8th write, opcode 15 is sent to dest 9 then dest 10; then ts=2.
- Timestep 2 reads: SPE0 read, write, read -> responses are opcode 2 with data 10 then 20, dest 9, each arriving 2 cycles after accept; hold out_ready low 3 cycles and check out_* stay stable.
- Protocol errors: read in ts 1, or opcode {3'd5, 0} -> err=1, no response, pointers unchanged.
- Completion: finish 8 writes in ts 2 -> FIN, done=1, in_ready=0; assert rst_n mid-BCAST in a rerun -> all outputs return to reset values.
- Spike counter with OMEM_SPIKE_CNT_EN: 3 spiking writes -> spike_cnt=3; clears to 0 at timestep end. Without the macro, spike_cnt stays 0.
